// File: rtl/uart_pkg.sv
// Shared constants for the UART command-frame parser.
//   HDR0/HDR1 : two-byte frame header (0x55, 0xAA)
//   ERR_*     : err_code values reported on frame_err
//   IDLE..CHK : parser state encoding
package uart_pkg;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR2    = 3'd1;
  localparam logic [2:0] CMD     = 3'd2;
  localparam logic [2:0] LEN     = 3'd3;
  localparam logic [2:0] PAYLOAD = 3'd4;
  localparam logic [2:0] CHK     = 3'd5;

endpackage

// File: rtl/frame_buf.sv
// Payload buffer: DEPTH x 8 register array.
//   sysclk, rst   : clock, async active-low reset (read register only)
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : registered read port, rdata valid one cycle after raddr
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Storage is left unreset; contents are don't-care until a frame is written.
  always_ff @(posedge sysclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles command frames (55 AA CMD LEN payload CHK) from a UART byte stream.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | hunting for first header byte 0x55
// HDR2    | got 0x55, expecting 0xAA (0x55 resyncs here)
// CMD     | next byte is the command
// LEN     | next byte is the payload length
// PAYLOAD | collecting LEN payload bytes into the buffer
// CHK     | next byte is the modulo-256 checksum
//
// Ports:
//   sysclk, rst        : clock, async active-low reset
//   rx_data, rx_done   : received byte and its one-cycle strobe
//   frame_valid        : pulse, a good frame has been stored
//   frame_cmd/len      : CMD/LEN of the last good frame
//   frame_pending      : good frame held until frame_ack
//   frame_ack          : consumer releases the buffer
//   rd_addr, rd_data   : payload read port (registered, 1-cycle latency)
//   frame_err/err_code : abort pulse and last error code
//   overrun            : sticky, a byte arrived while a frame was held
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 20000,
  parameter int AW          = 4
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic          frame_valid,
  output logic [7:0]    frame_cmd,
  output logic [7:0]    frame_len,
  output logic          frame_pending,
  input  logic          frame_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic          overrun
);

  localparam int             TW        = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TMO_LOAD  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]    state;
  logic [7:0]    sum;
  logic [7:0]    idx;
  logic [7:0]    cur_cmd;
  logic [7:0]    cur_len;
  logic [TW-1:0] tmo_cnt;
  logic          accept;
  logic          buf_we;

  // Discard is decided by the registered pending flag, so a byte arriving
  // together with frame_ack is still dropped.
  assign accept = rx_done & ~frame_pending;
  assign buf_we = accept && (state == PAYLOAD);

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_frame_buf (
    .sysclk (sysclk),
    .rst    (rst),
    .we     (buf_we),
    .waddr  (idx[AW-1:0]),
    .wdata  (rx_data),
    .raddr  (rd_addr),
    .rdata  (rd_data)
  );

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      sum           <= '0;
      idx           <= '0;
      cur_cmd       <= '0;
      cur_len       <= '0;
      tmo_cnt       <= '0;
      frame_valid   <= 1'b0;
      frame_cmd     <= '0;
      frame_len     <= '0;
      frame_pending <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= '0;
      overrun       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (frame_pending && frame_ack) begin
        frame_pending <= 1'b0;
        overrun       <= 1'b0;
      end else if (frame_pending && rx_done) begin
        overrun <= 1'b1;
      end

      // An accepted byte always beats a simultaneous timeout.
      if (accept) begin
        tmo_cnt <= TMO_LOAD;
        case (state)
          IDLE: begin
            if (rx_data == HDR0) state <= HDR2;
          end
          HDR2: begin
            if (rx_data == HDR1)      state <= CMD;
            else if (rx_data != HDR0) state <= IDLE;
          end
          CMD: begin
            cur_cmd <= rx_data;
            sum     <= rx_data;
            state   <= LEN;
          end
          LEN: begin
            if (rx_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= IDLE;
            end else begin
              cur_len <= rx_data;
              sum     <= sum + rx_data;
              idx     <= '0;
              state   <= (rx_data == 8'd0) ? CHK : PAYLOAD;
            end
          end
          PAYLOAD: begin
            sum <= sum + rx_data;
            idx <= idx + 8'd1;
            if (idx + 8'd1 == cur_len) state <= CHK;
          end
          CHK: begin
            if (rx_data == sum) begin
              frame_valid   <= 1'b1;
              frame_cmd     <= cur_cmd;
              frame_len     <= cur_len;
              frame_pending <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // Down-counter reaches zero TIMEOUT_CYC-1 cycles after the last byte.
        if (tmo_cnt == '0) begin
          frame_err <= 1'b1;
          err_code  <= ERR_TMO;
          state     <= IDLE;
        end else begin
          tmo_cnt <= tmo_cnt - TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int T       = 300;
  localparam int AW      = 4;

  logic          sysclk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          frame_valid;
  logic [7:0]    frame_cmd;
  logic [7:0]    frame_len;
  logic          frame_pending;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_err;
  logic [1:0]    err_code;
  logic          overrun;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(T), .AW(AW)) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .frame_valid   (frame_valid),
    .frame_cmd     (frame_cmd),
    .frame_len     (frame_len),
    .frame_pending (frame_pending),
    .frame_ack     (frame_ack),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .overrun       (overrun)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    bit         is_err;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [1:0] code;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  logic [7:0] mdl_buf [MAX_LEN];
  logic [7:0] mdl_cmd, mdl_len;

  logic [7:0] fq[$];
  logic [7:0] f_cmd, f_len;
  logic [7:0] f_pl [MAX_LEN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected event whenever the DUT pulses valid or err.
  always @(negedge sysclk) begin
    ev_t e;
    if (rst && (frame_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event valid=%0b err=%0b code=%0d t=%0t",
                 frame_valid, frame_err, err_code, $time);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", {30'd0, frame_err, frame_valid}, e.is_err ? 32'd2 : 32'd1);
        if (e.is_err) begin
          chk("err_code", err_code, e.code);
        end else begin
          chk("frame_cmd", frame_cmd, e.cmd);
          chk("frame_len", frame_len, e.len);
          chk("pending_at_valid", frame_pending, 1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge sysclk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge sysclk); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) @(posedge sysclk);
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], $urandom_range(0, 4));
  endtask

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'h55) b = 8'h00;
      send_byte(b, $urandom_range(0, 3));
    end
  endtask

  // Builds 55.. AA CMD LEN payload CHK into fq; bad=1 corrupts the checksum.
  task automatic make_good(input bit bad);
    int s, r;
    f_cmd = 8'($urandom);
    r = $urandom_range(0, 3);
    f_len = (r == 0) ? 8'd0 : (r == 1) ? 8'(MAX_LEN) : 8'($urandom_range(1, MAX_LEN - 1));
    s = int'(f_cmd) + int'(f_len);
    fq = {};
    repeat ($urandom_range(1, 3)) fq.push_back(8'h55);
    fq.push_back(8'hAA);
    fq.push_back(f_cmd);
    fq.push_back(f_len);
    for (int i = 0; i < int'(f_len); i++) begin
      f_pl[i] = 8'($urandom);
      s += int'(f_pl[i]);
      fq.push_back(f_pl[i]);
    end
    if (bad) fq.push_back(8'((s + $urandom_range(1, 255)) % 256));
    else     fq.push_back(8'(s % 256));
  endtask

  task automatic push_good();
    ev_t e;
    e.is_err = 1'b0;
    e.cmd    = f_cmd;
    e.len    = f_len;
    e.code   = 2'd0;
    exp_q.push_back(e);
    mdl_cmd = f_cmd;
    mdl_len = f_len;
    for (int i = 0; i < int'(f_len); i++) mdl_buf[i] = f_pl[i];
  endtask

  task automatic push_err(input logic [1:0] code);
    ev_t e;
    e.is_err = 1'b1;
    e.cmd    = 8'd0;
    e.len    = 8'd0;
    e.code   = code;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge sysclk);
      n++;
    end
    chk("event_seen", exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(posedge sysclk);
    #1;
  endtask

  task automatic check_held();
    chk("held_cmd", frame_cmd, mdl_cmd);
    chk("held_len", frame_len, mdl_len);
    chk("held_pending", frame_pending, 1);
    for (int i = 0; i < int'(mdl_len); i++) begin
      @(posedge sysclk); #1;
      rd_addr = AW'(i);
      @(posedge sysclk); #1;
      chk("rd_data", rd_data, mdl_buf[i]);
    end
  endtask

  task automatic do_ack();
    @(posedge sysclk); #1;
    frame_ack = 1'b1;
    @(posedge sysclk); #1;
    frame_ack = 1'b0;
    chk("ack_pending", frame_pending, 0);
    chk("ack_overrun", overrun, 0);
  endtask

  task automatic overrun_seq();
    chk("overrun_before", overrun, 0);
    send_junk($urandom_range(0, 2));
    make_good(0);
    send_list(fq);
    repeat (5) @(posedge sysclk);
    #1;
    chk("overrun_set", overrun, 1);
    check_held();
  endtask

  task automatic good_flow();
    check_held();
    if ($urandom_range(0, 1) == 1) overrun_seq();
    do_ack();
  endtask

  task automatic timeout_case();
    int k;
    bit abort;
    make_good(0);
    k = $urandom_range(1, fq.size() - 1);
    abort = bit'($urandom_range(0, 1));
    for (int i = 0; i < k - 1; i++) send_byte(fq[i], $urandom_range(0, 4));
    if (abort) begin
      push_err(2'd3);
      send_byte(fq[k-1], T - 1);
      send_byte(8'h00, 0);
      drain(40);
    end else begin
      push_good();
      send_byte(fq[k-1], T - 2);
      for (int i = k; i < fq.size(); i++) send_byte(fq[i], $urandom_range(0, 4));
      drain(60);
      good_flow();
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst = 1'b0; rx_data = 8'h00; rx_done = 1'b0; frame_ack = 1'b0; rd_addr = '0;
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_valid", frame_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_pending", frame_pending, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cmd", frame_cmd, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b1;
    repeat (2) @(posedge sysclk);

    // Good frame, then overrun while held, then ack.
    f_cmd = 8'h10; f_len = 8'd3; f_pl[0] = 8'h01; f_pl[1] = 8'h02; f_pl[2] = 8'h03;
    push_good();
    fq = {8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    send_list(fq);
    drain(40);
    check_held();
    chk("overrun_clear", overrun, 0);
    fq = {8'h55, 8'hAA, 8'h10, 8'h02, 8'h09, 8'h09, 8'h1B};
    send_list(fq);
    repeat (3) @(posedge sysclk);
    #1;
    chk("overrun_set", overrun, 1);
    check_held();
    do_ack();
    @(posedge sysclk); #1;
    frame_ack = 1'b1;
    @(posedge sysclk); #1;
    frame_ack = 1'b0;
    chk("idle_ack_pending", frame_pending, 0);

    // Checksum error.
    push_err(2'd2);
    fq = {8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18};
    send_list(fq);
    drain(40);
    chk("chk_err_pending", frame_pending, 0);

    // Length error, then a good frame.
    push_err(2'd1);
    fq = {8'h55, 8'hAA, 8'h20, 8'h11};
    send_list(fq);
    drain(40);
    make_good(0);
    push_good();
    send_list(fq);
    drain(60);
    check_held();
    // Byte alongside ack is dropped: the rest of the header must not complete a frame.
    @(posedge sysclk); #1;
    frame_ack = 1'b1; rx_done = 1'b1; rx_data = 8'h55;
    @(posedge sysclk); #1;
    frame_ack = 1'b0; rx_done = 1'b0;
    fq = {8'hAA, 8'h07, 8'h00, 8'h07};
    send_list(fq);
    repeat (5) @(posedge sysclk);
    #1;
    chk("ack_byte_pending", frame_pending, 0);

    // Resync and empty payload.
    f_cmd = 8'h07; f_len = 8'd0;
    push_good();
    fq = {8'h55, 8'h55, 8'hAA, 8'h07, 8'h00, 8'h07};
    send_list(fq);
    drain(40);
    check_held();
    do_ack();

    // Timeout: silence after CMD.
    push_err(2'd3);
    send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h10, 0);
    drain(T + 40);

    // Byte exactly at the timeout boundary keeps the frame alive.
    f_cmd = 8'h10; f_len = 8'd3; f_pl[0] = 8'h01; f_pl[1] = 8'h02; f_pl[2] = 8'h03;
    push_good();
    send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h10, T - 2);
    fq = {8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    send_list(fq);
    drain(40);
    check_held();
    do_ack();

    // One cycle later it times out.
    push_err(2'd3);
    send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h10, T - 1);
    send_byte(8'h03, 0);
    drain(40);

    // Reset mid-frame: no error, outputs cleared, no later timeout.
    send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h10, 0);
    @(posedge sysclk); #1;
    rst = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    chk("midrst_code", err_code, 0);
    chk("midrst_err", frame_err, 0);
    chk("midrst_pending", frame_pending, 0);
    rst = 1'b1;
    repeat (T + 20) @(posedge sysclk);

    // Randomised frames.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          send_junk($urandom_range(0, 2));
          make_good(0);
          push_good();
          send_list(fq);
          drain(60);
          good_flow();
        end
        2: begin
          make_good(1);
          push_err(2'd2);
          send_list(fq);
          drain(60);
          chk("rnd_chk_pending", frame_pending, 0);
        end
        3: begin
          f_cmd = 8'($urandom);
          f_len = ($urandom_range(0, 1) == 0) ? 8'(MAX_LEN + 1) : 8'($urandom_range(MAX_LEN + 1, 255));
          push_err(2'd1);
          fq = {8'h55, 8'hAA, f_cmd, f_len};
          send_list(fq);
          drain(40);
        end
        4: timeout_case();
        default: begin
          b = 8'($urandom);
          if (b == 8'h55 || b == 8'hAA) b = 8'h3C;
          fq = {8'h55, b};
          send_list(fq);
          make_good(0);
          push_good();
          send_list(fq);
          drain(60);
          good_flow();
        end
      endcase
    end

    drain(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Consumes the byte stream from the UART receiver (byte + single-cycle done strobe) and assembles command frames.
- Frame format: 0x55, 0xAA, CMD, LEN, LEN payload bytes, CHK. CHK is the 8-bit modulo-256 sum of CMD, LEN and all payload bytes.
- Validated frames are held in a payload buffer for the command layer to read. The frame is released by an ack handshake.
- Malformed, corrupted and stalled frames are reported with an error code.

Parameters:
MAX_LEN  16  maximum payload bytes; buffer depth; LEN > MAX_LEN is an error
TIMEOUT_CYC  20000  sysclk cycles allowed between bytes inside a frame (about 4.6 byte times at 115200 with a 50 MHz sysclk)
AW  4  buffer address width, equal to clog2(MAX_LEN)

Ports:
sysclk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  received byte; valid only in the cycle rx_done=1
rx_done  in  1  single-cycle byte strobe from the UART receiver
frame_valid  out  1  one-cycle pulse: a good frame is stored
frame_cmd  out  8  CMD of the last good frame
frame_len  out  8  LEN of the last good frame
frame_pending  out  1  level: a good frame is held and not yet acked
frame_ack  in  1  pulse: consumer has finished with the buffer
rd_addr  in  AW  payload read address
rd_data  out  8  payload byte; registered, valid 1 cycle after rd_addr
frame_err  out  1  one-cycle pulse on a frame abort
err_code  out  2  1 = LEN too large, 2 = checksum mismatch, 3 = timeout; holds the last code
overrun  out  1  sticky: a byte arrived while frame_pending=1

Behaviour:
- Reset: all outputs are 0, state is IDLE, counters are 0. Buffer contents are don't-care.
- Sampling: rx_data is captured only in the cycle rx_done=1. The upstream Data bus changes on the following cycle.
- States and transitions, on each rx_done while frame_pending=0:
  - IDLE: byte 0x55 goes to HDR2. Any other byte stays in IDLE with no error.
  - HDR2: 0xAA goes to CMD. 0x55 stays in HDR2 (resync). Any other byte goes to IDLE with no error.
  - CMD: store the byte, sum = byte, go to LEN.
  - LEN: if byte > MAX_LEN, pulse frame_err with code 1 and go to IDLE. Otherwise store it and add it to sum. LEN = 0 goes to CHK; LEN > 0 goes to PAYLOAD with idx = 0.
  - PAYLOAD: write buf[idx] = byte, add it to sum, increment idx. When idx reaches LEN, go to CHK.
  - CHK: if byte == sum[7:0], pulse frame_valid, load frame_cmd and frame_len, set frame_pending, go to IDLE. Otherwise pulse frame_err with code 2 and go to IDLE.
- Latency: frame_valid and frame_err assert in the cycle after the rx_done that triggers them.
- Timeout:
  - The counter runs in every state except IDLE and restarts at each accepted rx_done.
  - At TIMEOUT_CYC-1: pulse frame_err with code 3 and go to IDLE.
  - If rx_done arrives in the same cycle as the timeout, the byte wins and the counter restarts.
- Buffer hold:
  - While frame_pending=1, every rx_done byte is discarded, overrun is set, and the state stays IDLE.
  - frame_ack clears frame_pending and overrun on the next edge.
  - The registered value of frame_pending decides discard. A byte in the same cycle as frame_ack is still discarded.
  - frame_ack while frame_pending=0 is ignored.
- Buffer contents and frame_cmd/frame_len stay stable from frame_valid until the next frame writes payload.
- rd_addr >= frame_len returns stale data and is not checked.
- The sum is 8-bit and wraps modulo 256.
- A reset mid-frame aborts the frame immediately with no frame_err.

Decomposition:
- Package uart_pkg holds:
  - header constants HDR0 = 8'h55, HDR1 = 8'hAA;
  - error-code constants ERR_LEN, ERR_CHK, ERR_TMO;
  - the state encoding: IDLE, HDR2, CMD, LEN, PAYLOAD, CHK.
- Sub-module frame_buf: MAX_LEN x 8 register array with a synchronous write port and a registered read port.
- The FSM, checksum and timeout logic stay in uart_frame_parser.

Test Plan:
- Good frame: bytes 55 AA 10 03 01 02 03 19 -> one frame_valid, frame_cmd=0x10, frame_len=3, then rd_addr 0/1/2 -> rd_data 01/02/03; frame_pending=1 until frame_ack.
- Checksum error: 55 AA 10 03 01 02 03 18 -> frame_err with err_code=2, no frame_valid, frame_pending stays 0.
- Length error with MAX_LEN=16: 55 AA 20 11 -> frame_err with err_code=1 after the LEN byte; a following good frame is accepted.
- Resync and empty payload: 55 55 AA 07 00 07 -> frame_valid, frame_len=0, frame_cmd=0x07.
- Timeout: 55 AA 10 then no byte for TIMEOUT_CYC cycles -> frame_err with err_code=3. A byte at exactly TIMEOUT_CYC-1 must prevent the error.
- Overrun: a good frame is not acked, then 55 AA ... arrives -> bytes ignored, overrun=1 and payload unchanged; frame_ack -> overrun=0 and frame_pending=0.
